// File: rtl/rst_sequencer_pkg.sv
// rst_sequencer_pkg: shared types and helpers for the staged reset sequencer.
// Holds the sequencer state encoding and the timing-counter width function.
package rst_sequencer_pkg;

    // Encodings are architectural: they are visible on state_out when the
    // status feature is built.
    typedef enum logic [2:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_LOCK_FILT = 3'd2,
        ST_RELEASE   = 3'd3,
        ST_RUN       = 3'd4
    } state_t;

    localparam logic [7:0] RETRY_MAX = 8'hFF;

    // Width of the shared timing counter: enough for the largest timing
    // parameter, plus one bit of headroom.
    function automatic int unsigned cnt_width(
        input int unsigned a,
        input int unsigned b,
        input int unsigned c,
        input int unsigned d
    );
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return int'($clog2(m)) + 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for level signals crossing into i_clk.
// Asynchronous active-low reset; both stages reset to 0.
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // First stage may go metastable; second stage gives it a cycle to settle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/rst_sequencer.sv
// rst_sequencer: PLL reset control and staged release of N_DOMAINS resets.
// Runs entirely in the PLL reference clock domain (clk_in). All outputs are
// driven straight from flops so downstream reset nets never see decode glitches.
// Optional build macro RST_SEQUENCER_STATUS_EN adds state_out and retry_cnt_out.
module rst_sequencer
    import rst_sequencer_pkg::*;
#(
    parameter int unsigned N_DOMAINS      = 2,
    parameter int unsigned PLL_RST_CYCLES = 16,
    parameter int unsigned LOCK_TIMEOUT   = 65536,
    parameter int unsigned LOCK_FILTER    = 128,
    parameter int unsigned STAGE_CYCLES   = 128
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic                 pll_lock_in,
    input  logic                 sw_reset_in,
    output logic                 pll_reset_out,
    output logic [N_DOMAINS-1:0] rst_out,
    output logic                 ready_out
`ifdef RST_SEQUENCER_STATUS_EN
    ,
    output logic [2:0]           state_out,
    output logic [7:0]           retry_cnt_out
`endif
);

    localparam int unsigned CW = cnt_width(PLL_RST_CYCLES, LOCK_TIMEOUT,
                                           LOCK_FILTER, STAGE_CYCLES);
    localparam int unsigned KW = $clog2(N_DOMAINS + 1);

    localparam logic [CW-1:0] PLL_RST_LAST = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] FILTER_LAST  = CW'(LOCK_FILTER - 1);
    localparam logic [CW-1:0] STAGE_LAST   = CW'(STAGE_CYCLES - 1);
    localparam logic [KW-1:0] K_DONE       = KW'(N_DOMAINS);

    logic                 w_lock_s;
    logic                 w_sw_s;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CW-1:0]        r_cnt;
    logic [CW-1:0]        w_cnt_nxt;
    logic [KW-1:0]        r_k;
    logic [KW-1:0]        w_k_nxt;
    logic [N_DOMAINS-1:0] r_rst;
    logic [N_DOMAINS-1:0] w_rst_nxt;
    logic                 r_pll_rst;
    logic                 r_ready;

    sync_2ff #(.WIDTH(1)) u_sync_lock (
        .i_clk   (clk_in),
        .i_rst_n (rst_n_in),
        .i_d     (pll_lock_in),
        .o_q     (w_lock_s)
    );

    sync_2ff #(.WIDTH(1)) u_sync_sw (
        .i_clk   (clk_in),
        .i_rst_n (rst_n_in),
        .i_d     (sw_reset_in),
        .o_q     (w_sw_s)
    );

    // State, timing counter, stage index and registered outputs.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state   <= ST_PLL_RST;
            r_cnt     <= '0;
            r_k       <= '0;
            r_rst     <= '1;
            r_pll_rst <= 1'b1;
            r_ready   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_k       <= w_k_nxt;
            r_rst     <= w_rst_nxt;
            r_pll_rst <= (w_state_nxt == ST_PLL_RST);
            r_ready   <= (w_state_nxt == ST_RUN);
        end
    end

    // Next-state decode. r_cnt counts cycles spent in the current state and is
    // cleared on every state entry; since reset also clears it, the first
    // PLL_RST out of reset lasts its full length like every retry.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 1'b1;
        w_k_nxt     = r_k;
        w_rst_nxt   = r_rst;

        case (r_state)
            ST_PLL_RST: begin
                if (r_cnt == PLL_RST_LAST) begin
                    w_state_nxt = ST_WAIT_LOCK;
                    w_cnt_nxt   = '0;
                end
            end

            ST_WAIT_LOCK: begin
                if (w_lock_s) begin
                    w_state_nxt = ST_LOCK_FILT;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == TIMEOUT_LAST) begin
                    w_state_nxt = ST_PLL_RST;
                    w_cnt_nxt   = '0;
                end
            end

            ST_LOCK_FILT: begin
                if (!w_lock_s) begin
                    // Chatter: back to waiting with a fresh timeout, not a retry.
                    w_state_nxt = ST_WAIT_LOCK;
                    w_cnt_nxt   = '0;
                end else if (w_sw_s) begin
                    // Software reset held: keep the filter from completing.
                    w_cnt_nxt   = '0;
                end else if (r_cnt == FILTER_LAST) begin
                    w_state_nxt = ST_RELEASE;
                    w_cnt_nxt   = '0;
                    w_k_nxt     = '0;
                end
            end

            ST_RELEASE, ST_RUN: begin
                if (!w_lock_s) begin
                    // Lock loss outranks a simultaneous software reset.
                    w_state_nxt = ST_PLL_RST;
                    w_cnt_nxt   = '0;
                    w_k_nxt     = '0;
                    w_rst_nxt   = '1;
                end else if (w_sw_s) begin
                    w_state_nxt = ST_LOCK_FILT;
                    w_cnt_nxt   = '0;
                    w_k_nxt     = '0;
                    w_rst_nxt   = '1;
                end else if (r_state == ST_RUN) begin
                    w_cnt_nxt   = '0;
                end else if (r_k == K_DONE) begin
                    w_state_nxt = ST_RUN;
                    w_cnt_nxt   = '0;
                end else begin
                    // Release one domain each time the stage counter wraps to 0;
                    // entry clears it, so bit 0 goes on the first RELEASE edge.
                    if (r_cnt == '0) begin
                        for (int unsigned i = 0; i < N_DOMAINS; i++) begin
                            if (KW'(i) == r_k) begin
                                w_rst_nxt[i] = 1'b0;
                            end
                        end
                        w_k_nxt = r_k + 1'b1;
                    end
                    w_cnt_nxt = (r_cnt == STAGE_LAST) ? '0 : r_cnt + 1'b1;
                end
            end

            default: begin
                w_state_nxt = ST_PLL_RST;
                w_cnt_nxt   = '0;
                w_k_nxt     = '0;
                w_rst_nxt   = '1;
            end
        endcase
    end

    assign pll_reset_out = r_pll_rst;
    assign rst_out       = r_rst;
    assign ready_out     = r_ready;

`ifdef RST_SEQUENCER_STATUS_EN
    logic [7:0] r_retry;

    // Saturating count of lock timeouts; only the external reset clears it.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_retry <= '0;
        end else if ((r_state == ST_WAIT_LOCK) && (w_state_nxt == ST_PLL_RST)
                     && (r_retry != RETRY_MAX)) begin
            r_retry <= r_retry + 1'b1;
        end
    end

    assign state_out     = r_state;
    assign retry_cnt_out = r_retry;
`endif

endmodule

// File: tb/tb_rst_sequencer.sv
// tb_rst_sequencer: directed self-checking bench for rst_sequencer.
// Parameters N=3, PLL_RST=4, TIMEOUT=20, FILTER=8, STAGE=5. Inputs are driven
// and outputs sampled on the falling clock edge; t counts falling edges since
// the current scenario's reference point.
module tb_rst_sequencer;

    localparam int unsigned N = 3;

    logic         clk_in = 1'b0;
    logic         rst_n_in;
    logic         pll_lock_in;
    logic         sw_reset_in;
    logic         pll_reset_out;
    logic [N-1:0] rst_out;
    logic         ready_out;
`ifdef RST_SEQUENCER_STATUS_EN
    logic [2:0]   state_out;
    logic [7:0]   retry_cnt_out;
`endif

    int n_pass  = 0;
    int n_total = 0;
    int t       = 0;

    rst_sequencer #(
        .N_DOMAINS      (N),
        .PLL_RST_CYCLES (4),
        .LOCK_TIMEOUT   (20),
        .LOCK_FILTER    (8),
        .STAGE_CYCLES   (5)
    ) dut (
        .clk_in        (clk_in),
        .rst_n_in      (rst_n_in),
        .pll_lock_in   (pll_lock_in),
        .sw_reset_in   (sw_reset_in),
        .pll_reset_out (pll_reset_out),
        .rst_out       (rst_out),
        .ready_out     (ready_out)
`ifdef RST_SEQUENCER_STATUS_EN
        ,
        .state_out     (state_out),
        .retry_cnt_out (retry_cnt_out)
`endif
    );

    always #5 clk_in = ~clk_in;

    task automatic adv_to(input int target);
        while (t < target) begin
            @(negedge clk_in);
            t++;
        end
    endtask

    task automatic test_reset();
        rst_n_in = 1'b0; pll_lock_in = 1'b0; sw_reset_in = 1'b0;
        repeat (3) @(negedge clk_in);
        n_total++; if (pll_reset_out !== 1'b1) $display("FAIL reset_pll got=%b exp=1", pll_reset_out); else n_pass++;
        n_total++; if (rst_out !== 3'b111) $display("FAIL reset_rst got=%b exp=111", rst_out); else n_pass++;
        n_total++; if (ready_out !== 1'b0) $display("FAIL reset_ready got=%b exp=0", ready_out); else n_pass++;
`ifdef RST_SEQUENCER_STATUS_EN
        n_total++; if (state_out !== 3'd0) $display("FAIL reset_state got=%0d exp=0", state_out); else n_pass++;
        n_total++; if (retry_cnt_out !== 8'd0) $display("FAIL reset_retry got=%0d exp=0", retry_cnt_out); else n_pass++;
`endif
    endtask

    task automatic test_bringup();
        rst_n_in = 1'b1; t = 0;
        n_total++; if (pll_reset_out !== 1'b1) $display("FAIL bring_pll0 got=%b exp=1", pll_reset_out); else n_pass++;
        adv_to(3);
        n_total++; if (pll_reset_out !== 1'b1) $display("FAIL bring_pll3 got=%b exp=1", pll_reset_out); else n_pass++;
        adv_to(4);
        n_total++; if (pll_reset_out !== 1'b0) $display("FAIL bring_pll4 got=%b exp=0", pll_reset_out); else n_pass++;
        adv_to(10); pll_lock_in = 1'b1;
        adv_to(20);
        n_total++; if (rst_out !== 3'b111) $display("FAIL bring_rst20 got=%b exp=111", rst_out); else n_pass++;
`ifdef RST_SEQUENCER_STATUS_EN
        n_total++; if (state_out !== 3'd2) $display("FAIL bring_state20 got=%0d exp=2", state_out); else n_pass++;
`endif
        adv_to(21);
        n_total++; if (rst_out !== 3'b111) $display("FAIL bring_rst21 got=%b exp=111", rst_out); else n_pass++;
        adv_to(22);
        n_total++; if (rst_out !== 3'b110) $display("FAIL bring_rst22 got=%b exp=110", rst_out); else n_pass++;
        adv_to(26);
        n_total++; if (rst_out !== 3'b110) $display("FAIL bring_rst26 got=%b exp=110", rst_out); else n_pass++;
        adv_to(27);
        n_total++; if (rst_out !== 3'b100) $display("FAIL bring_rst27 got=%b exp=100", rst_out); else n_pass++;
        adv_to(31);
        n_total++; if (rst_out !== 3'b100) $display("FAIL bring_rst31 got=%b exp=100", rst_out); else n_pass++;
        adv_to(32);
        n_total++; if (rst_out !== 3'b000) $display("FAIL bring_rst32 got=%b exp=000", rst_out); else n_pass++;
        n_total++; if (ready_out !== 1'b0) $display("FAIL bring_ready32 got=%b exp=0", ready_out); else n_pass++;
        adv_to(33);
        n_total++; if (ready_out !== 1'b1) $display("FAIL bring_ready33 got=%b exp=1", ready_out); else n_pass++;
`ifdef RST_SEQUENCER_STATUS_EN
        n_total++; if (state_out !== 3'd4) $display("FAIL bring_state33 got=%0d exp=4", state_out); else n_pass++;
`endif
        adv_to(36);
    endtask

    task automatic test_lock_loss_run();
        t = 0; pll_lock_in = 1'b0;
        adv_to(2);
        n_total++; if (ready_out !== 1'b1) $display("FAIL loss_ready2 got=%b exp=1", ready_out); else n_pass++;
        adv_to(3);
        n_total++; if (rst_out !== 3'b111) $display("FAIL loss_rst3 got=%b exp=111", rst_out); else n_pass++;
        n_total++; if (ready_out !== 1'b0) $display("FAIL loss_ready3 got=%b exp=0", ready_out); else n_pass++;
        n_total++; if (pll_reset_out !== 1'b1) $display("FAIL loss_pll3 got=%b exp=1", pll_reset_out); else n_pass++;
        adv_to(6);
        n_total++; if (pll_reset_out !== 1'b1) $display("FAIL loss_pll6 got=%b exp=1", pll_reset_out); else n_pass++;
        adv_to(7);
        n_total++; if (pll_reset_out !== 1'b0) $display("FAIL loss_pll7 got=%b exp=0", pll_reset_out); else n_pass++;
        pll_lock_in = 1'b1;
        adv_to(18);
        n_total++; if (rst_out !== 3'b111) $display("FAIL loss_rst18 got=%b exp=111", rst_out); else n_pass++;
        adv_to(19);
        n_total++; if (rst_out !== 3'b110) $display("FAIL loss_rst19 got=%b exp=110", rst_out); else n_pass++;
        adv_to(24);
        n_total++; if (rst_out !== 3'b100) $display("FAIL loss_rst24 got=%b exp=100", rst_out); else n_pass++;
        adv_to(29);
        n_total++; if (rst_out !== 3'b000) $display("FAIL loss_rst29 got=%b exp=000", rst_out); else n_pass++;
        n_total++; if (ready_out !== 1'b0) $display("FAIL loss_ready29 got=%b exp=0", ready_out); else n_pass++;
        adv_to(30);
        n_total++; if (ready_out !== 1'b1) $display("FAIL loss_ready30 got=%b exp=1", ready_out); else n_pass++;
        adv_to(33);
    endtask

    task automatic test_sw_reset();
        logic pll_seen;
        pll_seen = 1'b0;
        t = 0; pll_lock_in = 1'b0;
        adv_to(7); pll_lock_in = 1'b1;
        adv_to(24);
        n_total++; if (rst_out !== 3'b100) $display("FAIL sw_rst24 got=%b exp=100", rst_out); else n_pass++;
        adv_to(25); sw_reset_in = 1'b1;
        adv_to(27);
        n_total++; if (rst_out !== 3'b100) $display("FAIL sw_rst27 got=%b exp=100", rst_out); else n_pass++;
        adv_to(28);
        n_total++; if (rst_out !== 3'b111) $display("FAIL sw_rst28 got=%b exp=111", rst_out); else n_pass++;
        n_total++; if (ready_out !== 1'b0) $display("FAIL sw_ready28 got=%b exp=0", ready_out); else n_pass++;
        sw_reset_in = 1'b0;
        while (t < 38) begin
            if (pll_reset_out !== 1'b0) pll_seen = 1'b1;
            adv_to(t + 1);
        end
        n_total++; if (pll_seen !== 1'b0) $display("FAIL sw_no_pll got=%b exp=0", pll_seen); else n_pass++;
        n_total++; if (rst_out !== 3'b111) $display("FAIL sw_rst38 got=%b exp=111", rst_out); else n_pass++;
        adv_to(39);
        n_total++; if (rst_out !== 3'b110) $display("FAIL sw_rst39 got=%b exp=110", rst_out); else n_pass++;
        adv_to(44);
        n_total++; if (rst_out !== 3'b100) $display("FAIL sw_rst44 got=%b exp=100", rst_out); else n_pass++;
        adv_to(49);
        n_total++; if (rst_out !== 3'b000) $display("FAIL sw_rst49 got=%b exp=000", rst_out); else n_pass++;
        adv_to(50);
        n_total++; if (ready_out !== 1'b1) $display("FAIL sw_ready50 got=%b exp=1", ready_out); else n_pass++;
        adv_to(53);
    endtask

    task automatic test_chatter();
        t = 0; pll_lock_in = 1'b0;
        adv_to(7); pll_lock_in = 1'b1;
        adv_to(14); pll_lock_in = 1'b0;
        adv_to(15); pll_lock_in = 1'b1;
`ifdef RST_SEQUENCER_STATUS_EN
        adv_to(16);
        n_total++; if (state_out !== 3'd2) $display("FAIL chat_state16 got=%0d exp=2", state_out); else n_pass++;
        adv_to(17);
        n_total++; if (state_out !== 3'd1) $display("FAIL chat_state17 got=%0d exp=1", state_out); else n_pass++;
        adv_to(18);
        n_total++; if (state_out !== 3'd2) $display("FAIL chat_state18 got=%0d exp=2", state_out); else n_pass++;
`endif
        adv_to(19);
        n_total++; if (rst_out !== 3'b111) $display("FAIL chat_rst19 got=%b exp=111", rst_out); else n_pass++;
        adv_to(26);
        n_total++; if (rst_out !== 3'b111) $display("FAIL chat_rst26 got=%b exp=111", rst_out); else n_pass++;
        n_total++; if (pll_reset_out !== 1'b0) $display("FAIL chat_pll26 got=%b exp=0", pll_reset_out); else n_pass++;
        adv_to(27);
        n_total++; if (rst_out !== 3'b110) $display("FAIL chat_rst27 got=%b exp=110", rst_out); else n_pass++;
        adv_to(37);
        n_total++; if (rst_out !== 3'b000) $display("FAIL chat_rst37 got=%b exp=000", rst_out); else n_pass++;
        adv_to(38);
        n_total++; if (ready_out !== 1'b1) $display("FAIL chat_ready38 got=%b exp=1", ready_out); else n_pass++;
        adv_to(41);
    endtask

    task automatic test_precedence();
        t = 0; pll_lock_in = 1'b0; sw_reset_in = 1'b1;
        adv_to(3);
        n_total++; if (pll_reset_out !== 1'b1) $display("FAIL prec_pll3 got=%b exp=1", pll_reset_out); else n_pass++;
        n_total++; if (rst_out !== 3'b111) $display("FAIL prec_rst3 got=%b exp=111", rst_out); else n_pass++;
`ifdef RST_SEQUENCER_STATUS_EN
        n_total++; if (state_out !== 3'd0) $display("FAIL prec_state3 got=%0d exp=0", state_out); else n_pass++;
`endif
        sw_reset_in = 1'b0;
        adv_to(7);
        n_total++; if (pll_reset_out !== 1'b0) $display("FAIL prec_pll7 got=%b exp=0", pll_reset_out); else n_pass++;
        pll_lock_in = 1'b1;
        adv_to(30);
        n_total++; if (ready_out !== 1'b1) $display("FAIL prec_ready30 got=%b exp=1", ready_out); else n_pass++;
        adv_to(33);
    endtask

    task automatic test_timeout();
        t = 0; pll_lock_in = 1'b0;
        adv_to(3);
        n_total++; if (pll_reset_out !== 1'b1) $display("FAIL tmo_pll3 got=%b exp=1", pll_reset_out); else n_pass++;
        adv_to(26);
        n_total++; if (pll_reset_out !== 1'b0) $display("FAIL tmo_pll26 got=%b exp=0", pll_reset_out); else n_pass++;
        adv_to(27);
        n_total++; if (pll_reset_out !== 1'b1) $display("FAIL tmo_pll27 got=%b exp=1", pll_reset_out); else n_pass++;
        n_total++; if (rst_out !== 3'b111) $display("FAIL tmo_rst27 got=%b exp=111", rst_out); else n_pass++;
`ifdef RST_SEQUENCER_STATUS_EN
        n_total++; if (retry_cnt_out !== 8'd1) $display("FAIL tmo_retry27 got=%0d exp=1", retry_cnt_out); else n_pass++;
`endif
        adv_to(30);
        n_total++; if (pll_reset_out !== 1'b1) $display("FAIL tmo_pll30 got=%b exp=1", pll_reset_out); else n_pass++;
        adv_to(31);
        n_total++; if (pll_reset_out !== 1'b0) $display("FAIL tmo_pll31 got=%b exp=0", pll_reset_out); else n_pass++;
        adv_to(50);
        n_total++; if (pll_reset_out !== 1'b0) $display("FAIL tmo_pll50 got=%b exp=0", pll_reset_out); else n_pass++;
        adv_to(51);
        n_total++; if (pll_reset_out !== 1'b1) $display("FAIL tmo_pll51 got=%b exp=1", pll_reset_out); else n_pass++;
        adv_to(74);
        n_total++; if (pll_reset_out !== 1'b0) $display("FAIL tmo_pll74 got=%b exp=0", pll_reset_out); else n_pass++;
`ifdef RST_SEQUENCER_STATUS_EN
        n_total++; if (retry_cnt_out !== 8'd2) $display("FAIL tmo_retry74 got=%0d exp=2", retry_cnt_out); else n_pass++;
`endif
        adv_to(75);
        n_total++; if (pll_reset_out !== 1'b1) $display("FAIL tmo_pll75 got=%b exp=1", pll_reset_out); else n_pass++;
        n_total++; if (ready_out !== 1'b0) $display("FAIL tmo_ready75 got=%b exp=0", ready_out); else n_pass++;
`ifdef RST_SEQUENCER_STATUS_EN
        n_total++; if (retry_cnt_out !== 8'd3) $display("FAIL tmo_retry75 got=%0d exp=3", retry_cnt_out); else n_pass++;
`endif
    endtask

    task automatic test_async_reset();
        int waited;
        pll_lock_in = 1'b1;
        waited = 0;
        while (ready_out !== 1'b1 && waited < 200) begin
            @(negedge clk_in);
            waited++;
        end
        n_total++; if (ready_out !== 1'b1) $display("FAIL arst_relock got=%b exp=1 after %0d cycles", ready_out, waited); else n_pass++;
`ifdef RST_SEQUENCER_STATUS_EN
        n_total++; if (retry_cnt_out !== 8'd3) $display("FAIL arst_retry_kept got=%0d exp=3", retry_cnt_out); else n_pass++;
`endif
        #2 rst_n_in = 1'b0;
        #1;
        n_total++; if (pll_reset_out !== 1'b1) $display("FAIL arst_pll got=%b exp=1", pll_reset_out); else n_pass++;
        n_total++; if (rst_out !== 3'b111) $display("FAIL arst_rst got=%b exp=111", rst_out); else n_pass++;
        n_total++; if (ready_out !== 1'b0) $display("FAIL arst_ready got=%b exp=0", ready_out); else n_pass++;
`ifdef RST_SEQUENCER_STATUS_EN
        n_total++; if (state_out !== 3'd0) $display("FAIL arst_state got=%0d exp=0", state_out); else n_pass++;
        n_total++; if (retry_cnt_out !== 8'd0) $display("FAIL arst_retry got=%0d exp=0", retry_cnt_out); else n_pass++;
`endif
        @(negedge clk_in);
        rst_n_in = 1'b1; t = 0;
        adv_to(3);
        n_total++; if (pll_reset_out !== 1'b1) $display("FAIL arst_pll3 got=%b exp=1", pll_reset_out); else n_pass++;
        adv_to(4);
        n_total++; if (pll_reset_out !== 1'b0) $display("FAIL arst_pll4 got=%b exp=0", pll_reset_out); else n_pass++;
        adv_to(13);
        n_total++; if (rst_out !== 3'b111) $display("FAIL arst_rst13 got=%b exp=111", rst_out); else n_pass++;
        adv_to(14);
        n_total++; if (rst_out !== 3'b110) $display("FAIL arst_rst14 got=%b exp=110", rst_out); else n_pass++;
        adv_to(24);
        n_total++; if (rst_out !== 3'b000) $display("FAIL arst_rst24 got=%b exp=000", rst_out); else n_pass++;
        n_total++; if (ready_out !== 1'b0) $display("FAIL arst_ready24 got=%b exp=0", ready_out); else n_pass++;
        adv_to(25);
        n_total++; if (ready_out !== 1'b1) $display("FAIL arst_ready25 got=%b exp=1", ready_out); else n_pass++;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog time limit reached passed=%0d total=%0d", n_pass, n_total);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_bringup();
        test_lock_loss_run();
        test_sw_reset();
        test_chatter();
        test_precedence();
        test_timeout();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
